reg_bank_irq: RTL and testbench

REG_BANK_IRQ -- requirements
Module: reg_bank_irq

---
 rtl/reg_bank_pkg.sv | 39 +++
 rtl/reg_bank_irq_ctrl.sv | 71 +++++++
 rtl/reg_bank_irq.sv | 224 ++++++++++++++++++++++
 tb/tb_reg_bank_irq.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : reg_bank_pkg                                                 |
// | Description : Shared address-map constants, access-type enum and address   |
// |               helper functions for the reg_bank_irq register block.        |
// |               The interrupt registers sit directly below STATUS_BASE, so   |
// |               their addresses are given as offsets below that base.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package reg_bank_pkg;

    // Decoded class of the address presented with a request.
    typedef enum logic [2:0] {
        ACC_CFG      = 3'd0,
        ACC_IRQ_MASK = 3'd1,
        ACC_IRQ_PEND = 3'd2,
        ACC_STATUS   = 3'd3,
        ACC_UNMAPPED = 3'd4
    } acc_type_e;

    // Distance of the interrupt registers below STATUS_BASE.
    localparam int unsigned c_IRQ_MASK_BELOW = 2;
    localparam int unsigned c_IRQ_PEND_BELOW = 1;

    // Status registers start at the midpoint of the address space.
    function automatic int unsigned status_base(input int unsigned addr_w);
        return 32'd1 << (addr_w - 1);
    endfunction

    function automatic int unsigned irq_mask_addr(input int unsigned addr_w);
        return status_base(addr_w) - c_IRQ_MASK_BELOW;
    endfunction

    function automatic int unsigned irq_pend_addr(input int unsigned addr_w);
        return status_base(addr_w) - c_IRQ_PEND_BELOW;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_bank_irq_ctrl                                            |
// | Description : Status change detection, pending capture, interrupt mask and |
// |               registered interrupt output.                                 |
// | Ports       : clk, rst          - clock, async active-high reset           |
// |               i_ro_regs         - packed status inputs                     |
// |               i_mask_we         - load i_mask_wdata into the mask          |
// |               i_mask_wdata      - new mask value                           |
// |               i_pend_clr        - write-1-to-clear pending bits            |
// |               o_mask, o_pend    - current mask / pending vectors           |
// |               o_irq             - OR(pending & mask), registered           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reg_bank_irq_ctrl
    import reg_bank_pkg::*;
#(
    parameter int REG_W      = 8,
    parameter int NUM_STATUS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_STATUS*REG_W-1:0] i_ro_regs,
    input  logic                        i_mask_we,
    input  logic [NUM_STATUS-1:0]       i_mask_wdata,
    input  logic [NUM_STATUS-1:0]       i_pend_clr,
    output logic [NUM_STATUS-1:0]       o_mask,
    output logic [NUM_STATUS-1:0]       o_pend,
    output logic                        o_irq
);

    logic [NUM_STATUS*REG_W-1:0] r_copy;
    logic                        r_armed;
    logic [NUM_STATUS-1:0]       w_change;
    logic [NUM_STATUS-1:0]       r_pend;
    logic [NUM_STATUS-1:0]       r_mask;
    logic                        r_irq;

    // A status register raises its event when any bit differs from last
    // cycle's copy. r_armed is low for the first cycle after reset so the
    // copy is loaded without generating spurious events.
    for (genvar k = 0; k < NUM_STATUS; k++) begin : g_change
        assign w_change[k] = r_armed &&
                             (i_ro_regs[k*REG_W +: REG_W] != r_copy[k*REG_W +: REG_W]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_copy  <= '0;
            r_armed <= 1'b0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_copy  <= i_ro_regs;
            r_armed <= 1'b1;
            // Set has priority over a simultaneous clear of the same bit.
            r_pend  <= (r_pend & ~i_pend_clr) | w_change;
            if (i_mask_we) begin
                r_mask <= i_mask_wdata;
            end
            r_irq   <= |(r_pend & r_mask);
        end
    end

    assign o_mask = r_mask;
    assign o_pend = r_pend;
    assign o_irq  = r_irq;

endmodule
`default_nettype wire

// File: rtl/reg_bank_irq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_bank_irq                                                 |
// | Description : Register bank with NUM_CFG read/write config registers,      |
// |               NUM_STATUS read-only status registers and an optional        |
// |               change-detect interrupt (IRQ_MASK / IRQ_PEND W1C).           |
// |               Every accepted request completes with a one-cycle ack        |
// |               carrying rdata and err.                                      |
// | Macro       : REG_BANK_IRQ_EN - builds the interrupt logic; without it the |
// |               IRQ registers are unmapped and irq is tied low.              |
// | Ports       : clk, rst  - clock, async active-high reset                   |
// |               ena       - block enable, requests dropped while low         |
// |               req, wr_rdn, addr, wdata - access request                    |
// |               ack, rdata, err          - completion (one cycle later)      |
// |               rw_regs   - packed config registers                          |
// |               ro_regs   - packed status inputs                             |
// |               irq       - interrupt output                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reg_bank_irq
    import reg_bank_pkg::*;
#(
    parameter int                       REG_W      = 8,
    parameter int                       ADDR_W     = 8,
    parameter int                       NUM_CFG    = 8,
    parameter int                       NUM_STATUS = 8,
    parameter logic [NUM_CFG*REG_W-1:0] CFG_RST    = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic                        req,
    input  logic                        wr_rdn,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [REG_W-1:0]            wdata,
    output logic                        ack,
    output logic [REG_W-1:0]            rdata,
    output logic                        err,
    output logic [NUM_CFG*REG_W-1:0]    rw_regs,
    input  logic [NUM_STATUS*REG_W-1:0] ro_regs,
    output logic                        irq
);

    localparam int unsigned c_STATUS_BASE = status_base(ADDR_W);

    logic [NUM_CFG*REG_W-1:0] r_cfg;
    logic                     r_ack;
    logic [REG_W-1:0]         r_rdata;
    logic                     r_err;

    logic                     w_accept;
    logic [NUM_CFG-1:0]       w_cfg_hit;
    logic [NUM_STATUS-1:0]    w_sts_hit;
    acc_type_e                w_acc;
    logic [REG_W-1:0]         w_cfg_rd;
    logic [REG_W-1:0]         w_sts_rd;
    logic [REG_W-1:0]         w_rdata_nxt;
    logic                     w_err_nxt;
    logic                     w_cfg_we;

    assign w_accept = req & ena;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_hit
        assign w_cfg_hit[k] = (addr == ADDR_W'(k));
    end

    for (genvar k = 0; k < NUM_STATUS; k++) begin : g_sts_hit
        assign w_sts_hit[k] = (addr == ADDR_W'(c_STATUS_BASE + k));
    end

`ifdef REG_BANK_IRQ_EN
    localparam logic [ADDR_W-1:0] c_MASK_ADDR = ADDR_W'(irq_mask_addr(ADDR_W));
    localparam logic [ADDR_W-1:0] c_PEND_ADDR = ADDR_W'(irq_pend_addr(ADDR_W));
`endif

    always_comb begin
        w_acc = ACC_UNMAPPED;
        if (|w_cfg_hit) begin
            w_acc = ACC_CFG;
        end else if (|w_sts_hit) begin
            w_acc = ACC_STATUS;
        end
`ifdef REG_BANK_IRQ_EN
        else if (addr == c_MASK_ADDR) begin
            w_acc = ACC_IRQ_MASK;
        end else if (addr == c_PEND_ADDR) begin
            w_acc = ACC_IRQ_PEND;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Interrupt controller
    // ------------------------------------------------------------------
`ifdef REG_BANK_IRQ_EN
    logic                  w_mask_we;
    logic [NUM_STATUS-1:0] w_pend_clr;
    logic [NUM_STATUS-1:0] w_mask;
    logic [NUM_STATUS-1:0] w_pend;
    logic                  w_irq;

    assign w_mask_we  = w_accept & wr_rdn & (w_acc == ACC_IRQ_MASK);
    assign w_pend_clr = (w_accept & wr_rdn & (w_acc == ACC_IRQ_PEND)) ?
                        wdata[NUM_STATUS-1:0] : '0;

    reg_bank_irq_ctrl #(
        .REG_W      (REG_W),
        .NUM_STATUS (NUM_STATUS)
    ) u_irq_ctrl (
        .clk          (clk),
        .rst          (rst),
        .i_ro_regs    (ro_regs),
        .i_mask_we    (w_mask_we),
        .i_mask_wdata (wdata[NUM_STATUS-1:0]),
        .i_pend_clr   (w_pend_clr),
        .o_mask       (w_mask),
        .o_pend       (w_pend),
        .o_irq        (w_irq)
    );

    assign irq = w_irq;
`else
    assign irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read data selection (one-hot hit vectors, OR-combined)
    // ------------------------------------------------------------------
    always_comb begin
        w_cfg_rd = '0;
        for (int k = 0; k < NUM_CFG; k++) begin
            if (w_cfg_hit[k]) begin
                w_cfg_rd = w_cfg_rd | r_cfg[k*REG_W +: REG_W];
            end
        end
    end

    // Status reads return the input as sampled on the request cycle.
    always_comb begin
        w_sts_rd = '0;
        for (int k = 0; k < NUM_STATUS; k++) begin
            if (w_sts_hit[k]) begin
                w_sts_rd = w_sts_rd | ro_regs[k*REG_W +: REG_W];
            end
        end
    end

    // Writes complete with rdata = 0; errored accesses change no state.
    always_comb begin
        w_rdata_nxt = '0;
        w_err_nxt   = 1'b0;
        case (w_acc)
            ACC_CFG: begin
                if (!wr_rdn) begin
                    w_rdata_nxt = w_cfg_rd;
                end
            end
            ACC_STATUS: begin
                if (wr_rdn) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_rdata_nxt = w_sts_rd;
                end
            end
`ifdef REG_BANK_IRQ_EN
            ACC_IRQ_MASK: begin
                if (!wr_rdn) begin
                    w_rdata_nxt = REG_W'(w_mask);
                end
            end
            ACC_IRQ_PEND: begin
                if (!wr_rdn) begin
                    w_rdata_nxt = REG_W'(w_pend);
                end
            end
`endif
            default: begin
                w_err_nxt = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Config registers
    // ------------------------------------------------------------------
    assign w_cfg_we = w_accept & wr_rdn & (w_acc == ACC_CFG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg <= CFG_RST;
        end else if (w_cfg_we) begin
            for (int k = 0; k < NUM_CFG; k++) begin
                if (w_cfg_hit[k]) begin
                    r_cfg[k*REG_W +: REG_W] <= wdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Completion: reset drops any accepted-but-unacknowledged request.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_ack   <= w_accept;
            r_rdata <= w_accept ? w_rdata_nxt : '0;
            r_err   <= w_accept & w_err_nxt;
        end
    end

    assign ack     = r_ack;
    assign rdata   = r_rdata;
    assign err     = r_err;
    assign rw_regs = r_cfg;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_irq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reg_bank_irq                                              |
// | Description : Self-checking bench for reg_bank_irq. Each step drives one   |
// |               cycle of stimulus, pushes the expected outputs from a        |
// |               behavioural model and pushes the observed outputs one cycle  |
// |               later; each test task drains and compares both queues.       |
// |               Interrupt scenarios are built when REG_BANK_IRQ_EN is set.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_reg_bank_irq;

    localparam int          REG_W       = 8;
    localparam int          ADDR_W      = 8;
    localparam int          NUM_CFG     = 8;
    localparam int          NUM_STATUS  = 8;
    localparam logic [63:0] CFG_RST     = 64'h8070_6050_4030_205A;
    localparam int          STATUS_BASE = 128;
    localparam int          MASK_ADDR   = 126;
    localparam int          PEND_ADDR   = 127;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        req;
    logic        wr_rdn;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [7:0]  rdata;
    logic        err;
    logic [63:0] rw_regs;
    logic [63:0] ro_regs;
    logic        irq;

    always #5 clk = ~clk;

    reg_bank_irq #(
        .REG_W      (REG_W),
        .ADDR_W     (ADDR_W),
        .NUM_CFG    (NUM_CFG),
        .NUM_STATUS (NUM_STATUS),
        .CFG_RST    (CFG_RST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .req     (req),
        .wr_rdn  (wr_rdn),
        .addr    (addr),
        .wdata   (wdata),
        .ack     (ack),
        .rdata   (rdata),
        .err     (err),
        .rw_regs (rw_regs),
        .ro_regs (ro_regs),
        .irq     (irq)
    );

    typedef struct packed {
        logic        ack;
        logic [7:0]  rdata;
        logic        err;
        logic        irq;
        logic [63:0] rw;
    } item_t;

    item_t exp_q[$];
    item_t obs_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Behavioural model state
    logic [7:0]  cfg_m [NUM_CFG];
    logic [7:0]  mask_m;
    logic [7:0]  pend_m;
    logic [63:0] ro_prev;
    logic [63:0] ro_cur;
    bit          armed;

    task automatic model_reset();
        for (int k = 0; k < NUM_CFG; k++) cfg_m[k] = CFG_RST[k*8 +: 8];
        mask_m  = '0;
        pend_m  = '0;
        ro_prev = '0;
        armed   = 1'b0;
    endtask

    // One clock of stimulus; expected values are computed from the model
    // state before the edge, the model is then advanced past the edge.
    task automatic step(input bit r, input bit w, input int a, input logic [7:0] d, input bit en);
        item_t e;
        item_t o;
`ifdef REG_BANK_IRQ_EN
        logic [7:0] clr;
        logic [7:0] chg;
        logic [7:0] mask_n;
        clr    = '0;
        chg    = '0;
        mask_n = mask_m;
`endif
        e     = '0;
        e.ack = r && en;
        e.irq = |(pend_m & mask_m);
        if (r && en) begin
            if (a < NUM_CFG) begin
                if (w) cfg_m[a] = d;
                else   e.rdata = cfg_m[a];
            end
`ifdef REG_BANK_IRQ_EN
            else if (a == MASK_ADDR) begin
                if (w) mask_n = d;
                else   e.rdata = mask_m;
            end else if (a == PEND_ADDR) begin
                if (w) clr = d;
                else   e.rdata = pend_m;
            end
`endif
            else if (a >= STATUS_BASE && a < STATUS_BASE + NUM_STATUS) begin
                if (w) e.err = 1'b1;
                else   e.rdata = ro_cur[(a - STATUS_BASE)*8 +: 8];
            end else begin
                e.err = 1'b1;
            end
        end
`ifdef REG_BANK_IRQ_EN
        for (int k = 0; k < NUM_STATUS; k++)
            chg[k] = armed && (ro_cur[k*8 +: 8] !== ro_prev[k*8 +: 8]);
        pend_m = (pend_m & ~clr) | chg;
        mask_m = mask_n;
`endif
        ro_prev = ro_cur;
        armed   = 1'b1;
        for (int k = 0; k < NUM_CFG; k++) e.rw[k*8 +: 8] = cfg_m[k];
        exp_q.push_back(e);

        req     = r;
        wr_rdn  = w;
        addr    = a[7:0];
        wdata   = d;
        ena     = en;
        ro_regs = ro_cur;
        @(negedge clk);
        o.ack   = ack;
        o.rdata = rdata;
        o.err   = err;
        o.irq   = irq;
        o.rw    = rw_regs;
        obs_q.push_back(o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 8'h00, 1'b1);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; ena = 1'b0; req = 1'b0; wr_rdn = 1'b0;
        addr = '0; wdata = '0; ro_cur = '0; ro_regs = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({ack, rdata, err, irq, rw_regs} !== {1'b0, 8'h00, 1'b0, 1'b0, CFG_RST}) begin
            n_fail++;
            $display("FAIL reset_state: ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h expected 0/00/0/0/%016h",
                     ack, rdata, err, irq, rw_regs, CFG_RST);
        end
        rst = 1'b0;
        model_reset();
        idle(2);
        // Accepted write, then reset arrives while its ack is showing.
        req = 1'b1; wr_rdn = 1'b1; addr = 8'd1; wdata = 8'h77; ena = 1'b1;
        @(posedge clk);
        #2;
        n_tests++;
        if (ack !== 1'b1 || rw_regs[15:8] !== 8'h77) begin
            n_fail++;
            $display("FAIL inflight_pre: ack=%0b reg1=%02h expected ack=1 reg1=77", ack, rw_regs[15:8]);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({ack, rdata, err, irq, rw_regs} !== {1'b0, 8'h00, 1'b0, 1'b0, CFG_RST}) begin
            n_fail++;
            $display("FAIL reset_async: ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h expected 0/00/0/0/%016h",
                     ack, rdata, err, irq, rw_regs, CFG_RST);
        end
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(3);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            item_t e; item_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_seq: ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h expected ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h",
                         o.ack, o.rdata, o.err, o.irq, o.rw, e.ack, e.rdata, e.err, e.irq, e.rw);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_cfg_rw();
        logic [7:0] v;
        step(1'b1, 1'b1, 3, 8'hA5, 1'b1);
        step(1'b1, 1'b0, 3, 8'h00, 1'b1);
        for (int k = 0; k < NUM_CFG; k++) begin
            v = 8'($urandom_range(0, 255));
            step(1'b1, 1'b1, k, v, 1'b1);
        end
        for (int k = NUM_CFG - 1; k >= 0; k--) step(1'b1, 1'b0, k, 8'h00, 1'b1);
        idle(1);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            item_t e; item_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL cfg_rw: ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h expected ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h",
                         o.ack, o.rdata, o.err, o.irq, o.rw, e.ack, e.rdata, e.err, e.irq, e.rw);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_errors();
        ro_cur = 64'h1122_3344_5566_7788;
        idle(2);
        step(1'b1, 1'b1, STATUS_BASE, 8'hFF, 1'b1);
        step(1'b1, 1'b0, NUM_CFG, 8'h00, 1'b1);
        step(1'b1, 1'b1, NUM_CFG, 8'h33, 1'b1);
        step(1'b1, 1'b0, 255, 8'h00, 1'b1);
        step(1'b1, 1'b1, STATUS_BASE + NUM_STATUS - 1, 8'h44, 1'b1);
        step(1'b1, 1'b0, STATUS_BASE + NUM_STATUS, 8'h00, 1'b1);
        step(1'b1, 1'b0, STATUS_BASE + NUM_STATUS - 1, 8'h00, 1'b1);
        idle(1);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            item_t e; item_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL errors: ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h expected ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h",
                         o.ack, o.rdata, o.err, o.irq, o.rw, e.ack, e.rdata, e.err, e.irq, e.rw);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Status inputs change every cycle; each read must return the value
    // presented on its own request cycle.
    task automatic test_status_read();
        for (int k = 0; k < NUM_STATUS; k++) begin
            ro_cur = {$urandom, $urandom};
            step(1'b1, 1'b0, STATUS_BASE + k, 8'h00, 1'b1);
        end
        idle(1);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            item_t e; item_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL status_read: ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h expected ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h",
                         o.ack, o.rdata, o.err, o.irq, o.rw, e.ack, e.rdata, e.err, e.irq, e.rw);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_ena_low();
        step(1'b1, 1'b1, 2, 8'h99, 1'b0);
        ro_cur[23:16] = ro_cur[23:16] ^ 8'h80;
        step(1'b1, 1'b0, 2, 8'h00, 1'b0);
        step(1'b1, 1'b0, 2, 8'h00, 1'b1);
        step(1'b1, 1'b0, PEND_ADDR, 8'h00, 1'b1);
        idle(1);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            item_t e; item_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ena_low: ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h expected ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h",
                         o.ack, o.rdata, o.err, o.irq, o.rw, e.ack, e.rdata, e.err, e.irq, e.rw);
            end
        end
    endtask

`ifdef REG_BANK_IRQ_EN
    // ------------------------------------------------------------------
    task automatic test_irq();
        ro_cur[7:0] = 8'h00;
        idle(2);
        step(1'b1, 1'b1, PEND_ADDR, 8'hFF, 1'b1);
        step(1'b1, 1'b1, MASK_ADDR, 8'h01, 1'b1);
        step(1'b1, 1'b0, MASK_ADDR, 8'h00, 1'b1);
        ro_cur[7:0] = 8'h10;
        idle(2);
        step(1'b1, 1'b0, PEND_ADDR, 8'h00, 1'b1);
        step(1'b1, 1'b1, PEND_ADDR, 8'h01, 1'b1);
        idle(2);
        ro_cur[23:16] = ro_cur[23:16] ^ 8'h01;
        idle(2);
        step(1'b1, 1'b1, MASK_ADDR, 8'h04, 1'b1);
        idle(2);
        step(1'b1, 1'b1, PEND_ADDR, 8'hFF, 1'b1);
        idle(2);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            item_t e; item_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL irq: ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h expected ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h",
                         o.ack, o.rdata, o.err, o.irq, o.rw, e.ack, e.rdata, e.err, e.irq, e.rw);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_w1c_collision();
        step(1'b1, 1'b1, MASK_ADDR, 8'h01, 1'b1);
        ro_cur[7:0] = ro_cur[7:0] ^ 8'h02;
        idle(2);
        // Clear of bit 0 lands on the same edge as a fresh change on status 0.
        ro_cur[7:0] = ro_cur[7:0] ^ 8'h01;
        step(1'b1, 1'b1, PEND_ADDR, 8'h01, 1'b1);
        idle(1);
        step(1'b1, 1'b0, PEND_ADDR, 8'h00, 1'b1);
        step(1'b1, 1'b1, PEND_ADDR, 8'h01, 1'b1);
        idle(2);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            item_t e; item_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL w1c_collision: ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h expected ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h",
                         o.ack, o.rdata, o.err, o.irq, o.rw, e.ack, e.rdata, e.err, e.irq, e.rw);
            end
        end
    endtask
`else
    // ------------------------------------------------------------------
    task automatic test_no_irq();
        step(1'b1, 1'b0, PEND_ADDR, 8'h00, 1'b1);
        step(1'b1, 1'b1, PEND_ADDR, 8'hFF, 1'b1);
        step(1'b1, 1'b1, MASK_ADDR, 8'hFF, 1'b1);
        step(1'b1, 1'b0, MASK_ADDR, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            ro_cur = {$urandom, $urandom};
            idle(1);
        end
        idle(2);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            item_t e; item_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL no_irq: ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h expected ack=%0b rdata=%02h err=%0b irq=%0b rw=%016h",
                         o.ack, o.rdata, o.err, o.irq, o.rw, e.ack, e.rdata, e.err, e.irq, e.rw);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cfg_rw();
        test_errors();
        test_status_read();
        test_ena_low();
`ifdef REG_BANK_IRQ_EN
        test_irq();
        test_w1c_collision();
`else
        test_no_irq();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
